bus_clock_recovery: RTL

BUS_CLOCK_RECOVERY -- requirements
Module: bus_clock_recovery

---
 rtl/bus_clock_pkg.sv | 19 +
 rtl/clk_edge_filter.sv | 71 +++++++
 rtl/bus_clock_recovery.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bus_clock_pkg.sv
// Shared defaults and helpers for the bus clock recovery block.
// Holds parameter defaults and the reference-period tolerance test.
package bus_clock_pkg;

    localparam int NCH_DEF    = 2;
    localparam int SYNC_DEF   = 2;
    localparam int DGL_DEF    = 2;
    localparam int REF_DEF    = 1;
    localparam int CNT_W_DEF  = 5;
    localparam int MID_DEF    = 3;
    localparam int NOM_DEF    = 16;
    localparam int TOL_DEF    = 1;
    localparam int LOCK_N_DEF = 4;

    function automatic logic period_in_tol(input int p, input int nom, input int tol);
        return (p >= nom - tol) && (p <= nom + tol);
    endfunction

endpackage

// File: rtl/clk_edge_filter.sv
// One bus clock channel: SYNC-stage synchroniser, DGL-sample deglitch filter,
// and one-cycle rise/fall strobes aligned with the filtered level change.
module clk_edge_filter
    import bus_clock_pkg::*;
#(
    parameter int SYNC = SYNC_DEF,
    parameter int DGL  = DGL_DEF
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clk_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam int            CW       = 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(DGL - 1);

    logic [SYNC-1:0] sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lvl_q, lvl_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            samp;

    assign samp = sync_q[SYNC-1];

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sync_d = {sync_q[SYNC-2:0], clk_in};
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (samp == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            lvl_d  = samp;
            rise_d = samp;
            fall_d = ~samp;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/bus_clock_recovery.sv
// Recovers phase and lock from external bus clocks: per-channel filtering,
// plus a phase counter, period measurement and lock tracking on channel REF.
module bus_clock_recovery
    import bus_clock_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int SYNC   = SYNC_DEF,
    parameter int DGL    = DGL_DEF,
    parameter int REF    = REF_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int MID    = MID_DEF,
    parameter int NOM    = NOM_DEF,
    parameter int TOL    = TOL_DEF,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [NCH-1:0]   clk_in,
    output logic [NCH-1:0]   lvl,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall,
    output logic [CNT_W-1:0] phase,
    output logic             mid,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             miss
);

    localparam logic [CNT_W-1:0] PH_MAX   = '1;
    localparam logic [CNT_W-1:0] MID_V    = CNT_W'(MID);
    localparam int               GW       = $clog2(LOCK_N + 1);
    localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_N);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_edge_filter #(
            .SYNC (SYNC),
            .DGL  (DGL)
        ) u_filt (
            .clk    (clk),
            .arst_n (arst_n),
            .clk_in (clk_in[i]),
            .lvl    (lvl[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [GW-1:0]    good_q, good_d;
    logic             mid_q, mid_d;
    logic             locked_q, locked_d;
    logic             miss_q, miss_d;
    logic             seen_q, seen_d;
    logic             to_done_q, to_done_d;
    logic             rise_ref;
    logic [CNT_W:0]   period_sum;
    logic [CNT_W-1:0] period_new;

    assign rise_ref   = rise[REF];
    assign period_sum = {1'b0, phase_q} + 1'b1;
    assign period_new = period_sum[CNT_W] ? PH_MAX : period_sum[CNT_W-1:0];

    always_comb begin
        phase_d   = phase_q;
        period_d  = period_q;
        good_d    = good_q;
        locked_d  = locked_q;
        miss_d    = 1'b0;
        seen_d    = seen_q;
        to_done_d = to_done_q;
        if (rise_ref) begin
            phase_d   = '0;
            to_done_d = 1'b0;
            if (seen_q) begin
                period_d = period_new;
                if (period_in_tol(int'(period_new), NOM, TOL)) begin
                    if (good_q != GOOD_MAX) good_d = good_q + 1'b1;
                    locked_d = (good_d == GOOD_MAX);
                end else begin
                    good_d   = '0;
                    locked_d = 1'b0;
                    miss_d   = 1'b1;
                end
            end else begin
                // The first reference edge only establishes a starting point.
                seen_d = 1'b1;
            end
        end else begin
            if (phase_q != PH_MAX) phase_d = phase_q + 1'b1;
            if (phase_d == PH_MAX && !to_done_q) begin
                good_d    = '0;
                locked_d  = 1'b0;
                miss_d    = 1'b1;
                to_done_d = 1'b1;
            end
        end
        mid_d = (phase_d == MID_V) && (phase_d != PH_MAX);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            phase_q   <= '0;
            period_q  <= '0;
            good_q    <= '0;
            mid_q     <= 1'b0;
            locked_q  <= 1'b0;
            miss_q    <= 1'b0;
            seen_q    <= 1'b0;
            to_done_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            period_q  <= period_d;
            good_q    <= good_d;
            mid_q     <= mid_d;
            locked_q  <= locked_d;
            miss_q    <= miss_d;
            seen_q    <= seen_d;
            to_done_q <= to_done_d;
        end
    end

    assign phase  = phase_q;
    assign period = period_q;
    assign mid    = mid_q;
    assign locked = locked_q;
    assign miss   = miss_q;

endmodule
